// File: rtl/fetch_stage_if.sv
// IF-stage signal bundle: hazard-control inputs, instruction-memory bus and IF/ID outputs.
// master is the fetch stage itself; slave is the surrounding pipeline/memory.
interface fetch_stage_if #(
   parameter int unsigned XLEN = 32
);
   logic            stall;
   logic            pc_sel;
   logic [XLEN-1:0] pc_target;
   logic [XLEN-1:0] imem_addr;
   logic [31:0]     imem_rdata;
   logic [XLEN-1:0] if_id_pc;
   logic [XLEN-1:0] if_id_pc4;
   logic [31:0]     if_id_instr;
   logic            if_id_valid;
   logic            flush_active;
   logic            misalign;
   logic [31:0]     fetch_count;

   modport master (
      input  stall, pc_sel, pc_target, imem_rdata,
      output imem_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid,
             flush_active, misalign, fetch_count
   );

   modport slave (
      output stall, pc_sel, pc_target, imem_rdata,
      input  imem_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid,
             flush_active, misalign, fetch_count
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, imem address, IF/ID register, redirect flush counter.
// Redirect beats flush, flush beats stall, stall beats normal fetch.
module fetch_stage #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_PC     = '0,
   parameter int unsigned     FLUSH_CYCLES = 1,
   parameter logic [31:0]     NOP_INSTR    = 32'h0000_0013
) (
   input logic            clk,
   input logic            rst_n,
   fetch_stage_if.master  bus
);

   // Counter holds the bubbles still owed after the redirect edge itself.
   localparam logic [1:0] FlushLoad = 2'(FLUSH_CYCLES - 1);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
   logic [31:0]     if_id_instr_q, if_id_instr_d;
   logic            if_id_valid_q, if_id_valid_d;
   logic [1:0]      flush_cnt_q, flush_cnt_d;
   logic            misalign_q, misalign_d;
   logic [31:0]     fetch_count_q, fetch_count_d;

   always_comb begin
      pc_d          = pc_q;
      if_id_pc_d    = if_id_pc_q;
      if_id_instr_d = if_id_instr_q;
      if_id_valid_d = if_id_valid_q;
      flush_cnt_d   = flush_cnt_q;
      misalign_d    = 1'b0;
      fetch_count_d = fetch_count_q;

      if (bus.pc_sel) begin
         pc_d          = {bus.pc_target[XLEN-1:2], 2'b00};
         if_id_pc_d    = '0;
         if_id_instr_d = NOP_INSTR;
         if_id_valid_d = 1'b0;
         flush_cnt_d   = FlushLoad;
         misalign_d    = |bus.pc_target[1:0];
      end else if (flush_cnt_q != 2'd0) begin
         if_id_pc_d    = '0;
         if_id_instr_d = NOP_INSTR;
         if_id_valid_d = 1'b0;
         flush_cnt_d   = flush_cnt_q - 2'd1;
      end else if (!bus.stall) begin
         if_id_pc_d    = pc_q;
         if_id_instr_d = bus.imem_rdata;
         if_id_valid_d = 1'b1;
         pc_d          = pc_q + XLEN'(4);
         fetch_count_d = fetch_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q          <= RESET_PC;
         if_id_pc_q    <= '0;
         if_id_instr_q <= NOP_INSTR;
         if_id_valid_q <= 1'b0;
         flush_cnt_q   <= 2'd0;
         misalign_q    <= 1'b0;
         fetch_count_q <= 32'd0;
      end else begin
         pc_q          <= pc_d;
         if_id_pc_q    <= if_id_pc_d;
         if_id_instr_q <= if_id_instr_d;
         if_id_valid_q <= if_id_valid_d;
         flush_cnt_q   <= flush_cnt_d;
         misalign_q    <= misalign_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   assign bus.imem_addr    = pc_q;
   assign bus.if_id_pc     = if_id_pc_q;
   assign bus.if_id_pc4    = if_id_pc_q + XLEN'(4);
   assign bus.if_id_instr  = if_id_instr_q;
   assign bus.if_id_valid  = if_id_valid_q;
   assign bus.flush_active = (flush_cnt_q != 2'd0);
   assign bus.misalign     = misalign_q;
   assign bus.fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: two instances (1 and 3 flush cycles) share stimulus; per-edge expected
// state is queued when inputs are driven and checked after the edge, plus directed spot checks.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ipc;
      logic [31:0] instr;
      logic        valid;
      logic [31:0] cnt;
      logic        mis;
      logic [31:0] fc;
   } mstate_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   mstate_t m1, m3;
   mstate_t q1[$];
   mstate_t q3[$];

   fetch_stage_if #(.XLEN(32)) if1 ();
   fetch_stage_if #(.XLEN(32)) if3 ();

   fetch_stage #(
      .XLEN(32), .RESET_PC(32'h0), .FLUSH_CYCLES(1), .NOP_INSTR(NOP)
   ) u_dut_n1 (
      .clk(clk), .rst_n(rst_n), .bus(if1)
   );

   fetch_stage #(
      .XLEN(32), .RESET_PC(32'h0), .FLUSH_CYCLES(3), .NOP_INSTR(NOP)
   ) u_dut_n3 (
      .clk(clk), .rst_n(rst_n), .bus(if3)
   );

   // Instruction memory: word at address a reads as 0xA0 + a.
   assign if1.imem_rdata = 32'hA0 + if1.imem_addr;
   assign if3.imem_rdata = 32'hA0 + if3.imem_addr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic mstate_t reset_state();
      mstate_t r;
      r.pc = 32'h0; r.ipc = 32'h0; r.instr = NOP; r.valid = 1'b0;
      r.cnt = 32'd0; r.mis = 1'b0; r.fc = 32'd0;
      return r;
   endfunction

   function automatic mstate_t step(mstate_t s, logic st, logic sel, logic [31:0] tgt, int n);
      mstate_t r = s;
      r.mis = 1'b0;
      if (sel) begin
         r.pc = tgt & ~32'h3; r.ipc = 32'h0; r.instr = NOP; r.valid = 1'b0;
         r.cnt = 32'(n - 1); r.mis = (tgt[1:0] != 2'b00);
      end else if (s.cnt != 0) begin
         r.ipc = 32'h0; r.instr = NOP; r.valid = 1'b0; r.cnt = s.cnt - 1;
      end else if (!st) begin
         r.ipc = s.pc; r.instr = 32'hA0 + s.pc; r.valid = 1'b1;
         r.pc = s.pc + 32'd4; r.fc = s.fc + 32'd1;
      end
      return r;
   endfunction

   task automatic cmp(input string who, input mstate_t e, input logic [31:0] addr,
                      input logic [31:0] ipc, input logic [31:0] ipc4, input logic [31:0] instr,
                      input logic valid, input logic fa, input logic mis, input logic [31:0] fc);
      check_eq({who, "_pc"}, addr, e.pc);
      check_eq({who, "_ifid_pc"}, ipc, e.ipc);
      check_eq({who, "_ifid_pc4"}, ipc4, e.ipc + 32'd4);
      check_eq({who, "_instr"}, instr, e.instr);
      check_eq({who, "_valid"}, 32'(valid), 32'(e.valid));
      check_eq({who, "_flush_active"}, 32'(fa), 32'(e.cnt != 0));
      check_eq({who, "_misalign"}, 32'(mis), 32'(e.mis));
      check_eq({who, "_fetch_count"}, fc, e.fc);
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic cycle(input logic st, input logic sel, input logic [31:0] tgt);
      mstate_t e;
      if1.stall = st; if1.pc_sel = sel; if1.pc_target = tgt;
      if3.stall = st; if3.pc_sel = sel; if3.pc_target = tgt;
      m1 = step(m1, st, sel, tgt, 1);
      m3 = step(m3, st, sel, tgt, 3);
      q1.push_back(m1);
      q3.push_back(m3);
      @(posedge clk);
      #1;
      check_eq("n1_sb_depth", 32'(q1.size()), 32'd1);
      if (q1.size() != 0) begin
         e = q1.pop_front();
         cmp("n1", e, if1.imem_addr, if1.if_id_pc, if1.if_id_pc4, if1.if_id_instr,
             if1.if_id_valid, if1.flush_active, if1.misalign, if1.fetch_count);
      end
      check_eq("n3_sb_depth", 32'(q3.size()), 32'd1);
      if (q3.size() != 0) begin
         e = q3.pop_front();
         cmp("n3", e, if3.imem_addr, if3.if_id_pc, if3.if_id_pc4, if3.if_id_instr,
             if3.if_id_valid, if3.flush_active, if3.misalign, if3.fetch_count);
      end
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string who, input logic [31:0] addr,
                                      input logic [31:0] instr, input logic valid,
                                      input logic fa, input logic [31:0] fc);
      check_eq({who, "_rst_pc"}, addr, 32'h0);
      check_eq({who, "_rst_instr"}, instr, NOP);
      check_eq({who, "_rst_valid"}, 32'(valid), 32'd0);
      check_eq({who, "_rst_flush"}, 32'(fa), 32'd0);
      check_eq({who, "_rst_fc"}, fc, 32'd0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      if1.stall = 1'b0; if1.pc_sel = 1'b0; if1.pc_target = 32'h0;
      if3.stall = 1'b0; if3.pc_sel = 1'b0; if3.pc_target = 32'h0;
      m1 = reset_state();
      m3 = reset_state();
      #7;
      check_reset_outputs("n1", if1.imem_addr, if1.if_id_instr, if1.if_id_valid,
                          if1.flush_active, if1.fetch_count);
      check_reset_outputs("n3", if3.imem_addr, if3.if_id_instr, if3.if_id_valid,
                          if3.flush_active, if3.fetch_count);
      @(negedge clk);
      rst_n = 1'b1;

      // Straight-line fetch to pc 8, then stall three cycles.
      cycle(0, 0, 0);
      cycle(0, 0, 0);
      for (int i = 0; i < 3; i++) cycle(1, 0, 0);
      check_eq("stall_pc", if1.imem_addr, 32'h8);
      check_eq("stall_ifid_pc", if1.if_id_pc, 32'h4);
      check_eq("stall_fc", if1.fetch_count, 32'd2);
      cycle(0, 0, 0);
      cycle(0, 0, 0);
      check_eq("run4_pc", if1.imem_addr, 32'd16);
      check_eq("run4_ifid_pc", if1.if_id_pc, 32'd12);
      check_eq("run4_fc", if3.fetch_count, 32'd4);

      // Redirect with one bubble.
      cycle(0, 1, 32'h100);
      check_eq("n1_redir_pc", if1.imem_addr, 32'h100);
      check_eq("n1_redir_valid", 32'(if1.if_id_valid), 32'd0);
      cycle(0, 0, 0);
      check_eq("n1_target_pc", if1.if_id_pc, 32'h100);
      check_eq("n1_target_valid", 32'(if1.if_id_valid), 32'd1);
      cycle(0, 0, 0);

      // Three-cycle flush with stall held; stall must not extend it.
      cycle(1, 1, 32'h200);
      check_eq("n3_flush_e1", 32'(if3.flush_active), 32'd1);
      cycle(1, 0, 0);
      check_eq("n3_flush_e2", 32'(if3.flush_active), 32'd1);
      cycle(1, 0, 0);
      check_eq("n3_flush_e3", 32'(if3.flush_active), 32'd0);
      check_eq("n3_flush_e3_valid", 32'(if3.if_id_valid), 32'd0);
      cycle(0, 0, 0);
      check_eq("n3_target_pc", if3.if_id_pc, 32'h200);
      check_eq("n3_target_instr", if3.if_id_instr, 32'h2A0);

      // Redirect overrides stall; misaligned target pulses misalign once.
      cycle(1, 1, 32'h42);
      check_eq("mis_pc", if3.imem_addr, 32'h40);
      check_eq("mis_pulse", 32'(if1.misalign), 32'd1);
      cycle(0, 0, 0);
      check_eq("mis_clear", 32'(if1.misalign), 32'd0);
      cycle(0, 0, 0);
      cycle(0, 0, 0);

      // Redirect during flush restarts the count.
      cycle(0, 1, 32'h280);
      cycle(0, 0, 0);
      cycle(0, 1, 32'h300);
      cycle(0, 0, 0);
      cycle(0, 0, 0);
      check_eq("n3_restart_bubble", 32'(if3.if_id_valid), 32'd0);
      cycle(0, 0, 0);
      check_eq("n3_restart_pc", if3.if_id_pc, 32'h300);
      check_eq("n3_restart_valid", 32'(if3.if_id_valid), 32'd1);

      // Asynchronous reset between edges while flushing.
      cycle(0, 1, 32'h500);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("n1_async", if1.imem_addr, if1.if_id_instr, if1.if_id_valid,
                          if1.flush_active, if1.fetch_count);
      check_reset_outputs("n3_async", if3.imem_addr, if3.if_id_instr, if3.if_id_valid,
                          if3.flush_active, if3.fetch_count);
      m1 = reset_state();
      m3 = reset_state();
      @(negedge clk);
      rst_n = 1'b1;
      cycle(0, 0, 0);
      cycle(0, 0, 0);
      check_eq("post_rst_pc", if3.imem_addr, 32'h8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
